crack_par: RTL

Parametrised ARC4 key-search controller: the next-generation cracker core. It walks a configurable slice of the key space (start, stride, last) and runs an external ARC4 engine once per candidate key. After each run it checks that the decrypted message is fully printable, and reports the first passing key. Several instances with distinct start values and a common stride split the key space for parallel cracking. An optional abort input lets a sibling core's success stop the search.

---
 rtl/crack_pkg.sv | 26 ++
 rtl/crack_scan.sv | 75 +++++++
 rtl/crack_par.sv | 125 ++++++++++++
 3 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the crack_par ARC4 key-search core.
package crack_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StRun,
    StLenReq,
    StLenGet,
    StChReq,
    StChGet,
    StCheck,
    StStep,
    StDone
  } crack_state_t;

  localparam logic [7:0] PR_LO_DEF = 8'h20;
  localparam logic [7:0] PR_HI_DEF = 8'h7E;
  localparam logic [7:0] LEN_ADDR  = 8'h00;

  function automatic logic is_printable(input logic [7:0] b, input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/crack_scan.sv
// Length fetch and printable-character scan of one decrypted message.
// done_o pulses in the deciding cycle; pass_o qualifies it.
module crack_scan
  import crack_pkg::*;
#(
  parameter logic [7:0] PR_LO = PR_LO_DEF,
  parameter logic [7:0] PR_HI = PR_HI_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kill_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic       pt_own,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
);

  crack_state_t state_q;
  logic [7:0]   len_q;
  logic [7:0]   idx_q;
  logic [7:0]   byte_q;
  logic         byte_ok;
  logic         last_ch;
  logic         empty_msg;

  assign byte_ok   = is_printable(byte_q, PR_LO, PR_HI);
  assign last_ch   = (idx_q == len_q);
  assign empty_msg = (state_q == StLenGet) && (ct_rddata == 8'd0);

  assign done_o  = empty_msg || (state_q == StCheck && (!byte_ok || last_ch));
  assign pass_o  = empty_msg || (state_q == StCheck && byte_ok && last_ch);
  assign ct_addr = LEN_ADDR;
  assign pt_own  = (state_q == StChReq);
  assign pt_addr = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      byte_q  <= 8'd0;
    end else if (kill_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start_i) state_q <= StLenReq;
        StLenReq: state_q <= StLenGet;
        StLenGet: begin
          len_q   <= ct_rddata;
          idx_q   <= 8'd1;
          state_q <= (ct_rddata == 8'd0) ? StIdle : StChReq;
        end
        StChReq:  state_q <= StChGet;
        StChGet: begin
          byte_q  <= pt_rddata;
          state_q <= StCheck;
        end
        StCheck: begin
          if (!byte_ok || last_ch) begin
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= StChReq;
          end
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/crack_par.sv
// ARC4 key-search controller walking KEY_START..KEY_LAST by KEY_STRIDE.
// Define CRACK_ABORT_EN to honour the abort input; otherwise it is ignored.
module crack_par
  import crack_pkg::*;
#(
  parameter int unsigned      KEY_W      = 24,
  parameter logic [KEY_W-1:0] KEY_START  = '0,
  parameter int unsigned      KEY_STRIDE = 1,
  parameter logic [KEY_W-1:0] KEY_LAST   = '1,
  parameter logic [7:0]       PR_LO      = PR_LO_DEF,
  parameter logic [7:0]       PR_HI      = PR_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic             abort,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_rddata,
  output logic             pt_own,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
);

  crack_state_t     state_q;
  logic [KEY_W-1:0] key_q;
  logic             kv_q;
  logic             run_seen_q;
  logic [KEY_W:0]   nxt_key;
  logic             abort_hit;
  logic             scan_start;
  logic             scan_done;
  logic             scan_pass;
  logic             scan_win;

  assign rdy = (state_q == StIdle) || (state_q == StDone);

`ifdef CRACK_ABORT_EN
  assign abort_hit = abort && !rdy;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Extra top bit catches wrap past the end of the key space.
  assign nxt_key    = {1'b0, key_q} + (KEY_W + 1)'(KEY_STRIDE);
  assign scan_start = (state_q == StRun) && run_seen_q && a4_rdy && !abort_hit;
  assign scan_win   = scan_done && scan_pass;

  assign a4_en     = (state_q == StArm) && a4_rdy && !abort_hit && !rst;
  assign key       = key_q;
  assign key_valid = kv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      key_q      <= KEY_START;
      kv_q       <= 1'b0;
      run_seen_q <= 1'b0;
    end else if (abort_hit && !scan_win) begin
      state_q <= StDone;
      kv_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (en) begin
            key_q   <= KEY_START;
            kv_q    <= 1'b0;
            state_q <= StArm;
          end
        end
        StArm: begin
          if (a4_rdy) begin
            run_seen_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        // First RUN cycle skipped: a4_rdy may not yet reflect the new start.
        StRun: begin
          if (!run_seen_q) run_seen_q <= 1'b1;
          else if (a4_rdy) state_q <= StLenReq;
        end
        // StLenReq stands for the whole scan handled by crack_scan.
        StLenReq: begin
          if (scan_done) begin
            kv_q    <= scan_pass;
            state_q <= scan_pass ? StDone : StStep;
          end
        end
        StStep: begin
          if (nxt_key > {1'b0, KEY_LAST}) begin
            state_q <= StDone;
          end else begin
            key_q   <= nxt_key[KEY_W-1:0];
            state_q <= StArm;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  crack_scan #(
    .PR_LO(PR_LO),
    .PR_HI(PR_HI)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (abort_hit),
    .start_i  (scan_start),
    .done_o   (scan_done),
    .pass_o   (scan_pass),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_own   (pt_own),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata)
  );

endmodule
